// File: rtl/ssd_cmd_decoder_pkg.sv
// Shared definitions for the SSD1306 command decoder: opcodes, addressing
// modes, command FSM states and register reset values.
package ssd_cmd_decoder_pkg;

  localparam logic [7:0] OP_SET_MODE    = 8'h20;
  localparam logic [7:0] OP_COL_RANGE   = 8'h21;
  localparam logic [7:0] OP_PAGE_RANGE  = 8'h22;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
  localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
  localparam logic [7:0] OP_COM_PINS    = 8'hDA;
  localparam logic [7:0] OP_VCOMH       = 8'hDB;

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'd0,
    MODE_VERT  = 2'd1,
    MODE_PAGE  = 2'd2
  } addr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } cmd_state_e;

  localparam logic [7:0] RST_CONTRAST = 8'h7F;
  localparam logic [6:0] RST_COL_END  = 7'd127;
  localparam logic [2:0] RST_PAGE_END = 3'd7;

  function automatic logic takes_two_args(input logic [7:0] op);
    return (op == OP_COL_RANGE) || (op == OP_PAGE_RANGE);
  endfunction

  function automatic logic takes_one_arg(input logic [7:0] op);
    return (op == OP_SET_MODE)    || (op == OP_CONTRAST)   ||
           (op == OP_CHARGE_PUMP) || (op == OP_MUX_RATIO)  ||
           (op == OP_DISP_OFFSET) || (op == OP_CLK_DIV)    ||
           (op == OP_PRECHARGE)   || (op == OP_COM_PINS)   ||
           (op == OP_VCOMH);
  endfunction

endpackage

// File: rtl/ssd_cmd_decoder_deser.sv
// Serial-to-byte deserialiser: bit counter, 7-bit shift register and the
// completed-byte strobe, which fires combinationally on the 8th bit edge.
module ssd_deser (
  input  logic       wclk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       dc,
  input  logic       sdin,
  output logic [2:0] bitcnt,
  output logic       byte_done,
  output logic [7:0] byte_val,
  output logic       byte_dc
);

  logic [6:0] shreg;

  // Deselect only realigns the bit counter; partial shift contents are
  // flushed naturally by the next 8 bits.
  always_ff @(posedge wclk) begin
    if (reset) begin
      bitcnt <= '0;
      shreg  <= '0;
    end else if (cs_n) begin
      bitcnt <= '0;
    end else begin
      bitcnt <= bitcnt + 3'd1;
      shreg  <= {shreg[5:0], sdin};
    end
  end

  assign byte_done = ~cs_n & (bitcnt == 3'd7);
  assign byte_val  = {shreg, sdin};
  assign byte_dc   = dc;

endmodule

// File: rtl/ssd_cmd_decoder.sv
// SSD1306 command/data decoder driving a 1-bit framebuffer write port.
// Define SSD_ADDR_MODES_EN to enable opcodes 0x20/0x21/0x22 and horizontal/vertical addressing.
module ssd_cmd_decoder
  import ssd_cmd_decoder_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              wclk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              dc,
  input  logic              sdin,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_data,
  output logic              invert,
  output logic              display_on,
  output logic [7:0]        contrast
);

  logic [2:0] bitcnt;
  logic       byte_done;
  logic [7:0] byte_val;
  logic       byte_dc;

  ssd_deser u_deser (
    .wclk      (wclk),
    .reset     (reset),
    .cs_n      (cs_n),
    .dc        (dc),
    .sdin      (sdin),
    .bitcnt    (bitcnt),
    .byte_done (byte_done),
    .byte_val  (byte_val),
    .byte_dc   (byte_dc)
  );

  cmd_state_e state, state_nxt;
  logic [7:0] pend_op, pend_nxt;
  logic [2:0] page, page_inc;
  logic [6:0] col, col_inc;

  logic cmd_byte, data_byte;
  logic set_col_lo, set_col_hi, set_page, set_invert, set_disp, set_contrast;
  logic set_mode, set_col_start, set_col_end, set_page_start, set_page_end;

  assign cmd_byte  = byte_done & ~byte_dc;
  assign data_byte = byte_done & byte_dc;

  // state | meaning: IDLE awaits an opcode; ARG1/ARG2 collect arguments of pend_op
  always_ff @(posedge wclk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pend_op <= '0;
    end else begin
      state   <= state_nxt;
      pend_op <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_op;
    if (data_byte) begin
      state_nxt = ST_IDLE;
    end else if (cmd_byte) begin
      case (state)
        ST_IDLE: begin
          if (takes_one_arg(byte_val) || takes_two_args(byte_val)) begin
            state_nxt = ST_ARG1;
            pend_nxt  = byte_val;
          end
        end
        ST_ARG1: state_nxt = takes_two_args(pend_op) ? ST_ARG2 : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    set_col_lo     = 1'b0;
    set_col_hi     = 1'b0;
    set_page       = 1'b0;
    set_invert     = 1'b0;
    set_disp       = 1'b0;
    set_contrast   = 1'b0;
    set_mode       = 1'b0;
    set_col_start  = 1'b0;
    set_col_end    = 1'b0;
    set_page_start = 1'b0;
    set_page_end   = 1'b0;
    if (cmd_byte) begin
      case (state)
        ST_IDLE: begin
          set_col_lo = (byte_val[7:4] == 4'h0);
          set_col_hi = (byte_val[7:4] == 4'h1);
          set_page   = (byte_val[7:3] == 5'b10110);
          set_invert = (byte_val[7:1] == 7'b1010011);
          set_disp   = (byte_val[7:1] == 7'b1010111);
        end
        ST_ARG1: begin
          set_contrast   = (pend_op == OP_CONTRAST);
          set_mode       = (pend_op == OP_SET_MODE) && (byte_val[1:0] != 2'd3);
          set_col_start  = (pend_op == OP_COL_RANGE);
          set_page_start = (pend_op == OP_PAGE_RANGE);
        end
        ST_ARG2: begin
          set_col_end  = (pend_op == OP_COL_RANGE);
          set_page_end = (pend_op == OP_PAGE_RANGE);
        end
        default: ;
      endcase
    end
  end

`ifdef SSD_ADDR_MODES_EN
  addr_mode_e addr_mode;
  logic [6:0] col_start, col_end;
  logic [2:0] page_start, page_end;

  always_ff @(posedge wclk) begin
    if (reset) begin
      addr_mode  <= MODE_PAGE;
      col_start  <= '0;
      col_end    <= RST_COL_END;
      page_start <= '0;
      page_end   <= RST_PAGE_END;
    end else begin
      if (set_mode)       addr_mode  <= addr_mode_e'(byte_val[1:0]);
      if (set_col_start)  col_start  <= byte_val[6:0];
      if (set_col_end)    col_end    <= byte_val[6:0];
      if (set_page_start) page_start <= byte_val[2:0];
      if (set_page_end)   page_end   <= byte_val[2:0];
    end
  end

  always_comb begin
    page_inc = page;
    col_inc  = col;
    case (addr_mode)
      MODE_HORIZ: begin
        if (col == col_end) begin
          col_inc  = col_start;
          page_inc = (page == page_end) ? page_start : page + 3'd1;
        end else begin
          col_inc = col + 7'd1;
        end
      end
      MODE_VERT: begin
        if (page == page_end) begin
          page_inc = page_start;
          col_inc  = (col == col_end) ? col_start : col + 7'd1;
        end else begin
          page_inc = page + 3'd1;
        end
      end
      default: col_inc = col + 7'd1;
    endcase
  end
`else
  // Page mode only: column wraps 127 -> 0 through the natural 7-bit overflow.
  always_comb begin
    page_inc = page;
    col_inc  = col + 7'd1;
  end
`endif

  always_ff @(posedge wclk) begin
    if (reset) begin
      page       <= '0;
      col        <= '0;
      contrast   <= RST_CONTRAST;
      invert     <= 1'b0;
      display_on <= 1'b0;
    end else if (data_byte) begin
      page <= page_inc;
      col  <= col_inc;
    end else begin
      if (set_col_lo)   col[3:0]   <= byte_val[3:0];
      if (set_col_hi)   col[6:4]   <= byte_val[2:0];
      if (set_page)     page       <= byte_val[2:0];
      if (set_invert)   invert     <= byte_val[0];
      if (set_disp)     display_on <= byte_val[0];
      if (set_contrast) contrast   <= byte_val;
`ifdef SSD_ADDR_MODES_EN
      if (set_col_start)  col  <= byte_val[6:0];
      if (set_page_start) page <= byte_val[2:0];
`endif
    end
  end

  assign fb_we   = ~cs_n & dc & ~reset;
  assign fb_addr = ADDR_W'({page, col, bitcnt});
  assign fb_data = sdin;

endmodule

// File: tb/tb_ssd_cmd_decoder.sv
// Directed bench for ssd_cmd_decoder: byte vector table plus hand-written
// sequences for deselect, reset and mid-byte dc corner cases.
module tb_ssd_cmd_decoder;

  logic        wclk;
  logic        reset;
  logic        cs_n;
  logic        dc;
  logic        sdin;
  logic        fb_we;
  logic [12:0] fb_addr;
  logic        fb_data;
  logic        invert;
  logic        display_on;
  logic [7:0]  contrast;

  int n_cmp = 0;
  int n_err = 0;

  ssd_cmd_decoder #(.ADDR_W(13)) dut (
    .wclk       (wclk),
    .reset      (reset),
    .cs_n       (cs_n),
    .dc         (dc),
    .sdin       (sdin),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .invert     (invert),
    .display_on (display_on),
    .contrast   (contrast)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic        rst;
    logic        dc;
    logic [7:0]  b;
    logic [12:0] addr;
    logic        inv;
    logic        on;
    logic [7:0]  con;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic av(input logic r, input logic d, input logic [7:0] b,
                    input logic [12:0] a, input logic i, input logic o, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.dc = d; v.b = b; v.addr = a; v.inv = i; v.on = o; v.con = c;
    vecs.push_back(v);
  endtask

  task automatic chk_flags(input string tag, input logic i, input logic o, input logic [7:0] c);
    chk({tag, ".invert"}, {31'd0, invert}, {31'd0, i});
    chk({tag, ".display_on"}, {31'd0, display_on}, {31'd0, o});
    chk({tag, ".contrast"}, {24'd0, contrast}, {24'd0, c});
  endtask

  task automatic send_bit(input logic d, input logic s, input logic [12:0] exp_a, input string tag);
    @(negedge wclk);
    reset = 1'b0; cs_n = 1'b0; dc = d; sdin = s;
    #1;
    chk({tag, ".fb_addr"}, {19'd0, fb_addr}, {19'd0, exp_a});
    chk({tag, ".fb_we"}, {31'd0, fb_we}, {31'd0, d});
    chk({tag, ".fb_data"}, {31'd0, fb_data}, {31'd0, s});
  endtask

  // dcs gives the dc level per bit, MSB-first like the byte itself
  task automatic send_byte(input logic [7:0] dcs, input logic [7:0] b,
                           input logic [12:0] base, input string tag);
    logic [7:0] bv;
    logic [7:0] dv;
    bv = b;
    dv = dcs;
    for (int k = 0; k < 8; k++)
      send_bit(dv[7-k], bv[7-k], base + 13'(k), tag);
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge wclk);
    reset = 1'b1; cs_n = 1'b0; dc = 1'b1; sdin = 1'b1;
    #1;
    chk({tag, ".rst_fb_we"}, {31'd0, fb_we}, 32'd0);
    @(posedge wclk);
    #1;
    chk({tag, ".rst_fb_addr"}, {19'd0, fb_addr}, 32'd0);
    chk_flags({tag, ".rst"}, 1'b0, 1'b0, 8'h7F);
    @(negedge wclk);
    reset = 1'b0; cs_n = 1'b1; dc = 1'b0; sdin = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cs_n = 1'b1; dc = 1'b0; sdin = 1'b0;

    // Page mode pointers, col wrap 127 -> 0
    av(1, 0, 8'hB3, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h05, 13'd3072, 0, 0, 8'h7F);
    av(0, 0, 8'h12, 13'd3112, 0, 0, 8'h7F);
    av(0, 1, 8'hA5, 13'd3368, 0, 0, 8'h7F);
    av(0, 0, 8'hE3, 13'd3376, 0, 0, 8'h7F);
    av(0, 0, 8'h0F, 13'd3376, 0, 0, 8'h7F);
    av(0, 0, 8'h17, 13'd3448, 0, 0, 8'h7F);
    av(0, 1, 8'h3C, 13'd4088, 0, 0, 8'h7F);
    av(0, 0, 8'hE3, 13'd3072, 0, 0, 8'h7F);
    // Argument skipping, display flags, contrast, data aborting a command
    av(1, 0, 8'hA8, 13'd0, 0, 0, 8'h7F);
    av(0, 0, 8'hA6, 13'd0, 0, 0, 8'h7F);
    av(0, 0, 8'hA7, 13'd0, 1, 0, 8'h7F);
    av(0, 0, 8'h81, 13'd0, 1, 0, 8'h7F);
    av(0, 0, 8'h3C, 13'd0, 1, 0, 8'h3C);
    av(0, 0, 8'hAF, 13'd0, 1, 1, 8'h3C);
    av(0, 0, 8'hAE, 13'd0, 1, 0, 8'h3C);
    av(0, 0, 8'h8D, 13'd0, 1, 0, 8'h3C);
    av(0, 0, 8'hAF, 13'd0, 1, 0, 8'h3C);
    av(0, 0, 8'h81, 13'd0, 1, 0, 8'h3C);
    av(0, 1, 8'h55, 13'd0, 1, 0, 8'h3C);
    av(0, 0, 8'hA6, 13'd8, 0, 0, 8'h3C);
`ifdef SSD_ADDR_MODES_EN
    // Horizontal mode over a 2x2 window, mode value 3 ignored
    av(1, 0, 8'h20, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h00, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h21, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h7E, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h7F, 13'd1008, 0, 0, 8'h7F);
    av(0, 0, 8'h22, 13'd1008, 0, 0, 8'h7F);
    av(0, 0, 8'h06, 13'd1008, 0, 0, 8'h7F);
    av(0, 0, 8'h07, 13'd7152, 0, 0, 8'h7F);
    av(0, 1, 8'h11, 13'd7152, 0, 0, 8'h7F);
    av(0, 1, 8'h22, 13'd7160, 0, 0, 8'h7F);
    av(0, 1, 8'h33, 13'd8176, 0, 0, 8'h7F);
    av(0, 1, 8'h44, 13'd8184, 0, 0, 8'h7F);
    av(0, 1, 8'h55, 13'd7152, 0, 0, 8'h7F);
    av(0, 0, 8'h20, 13'd7160, 0, 0, 8'h7F);
    av(0, 0, 8'h03, 13'd7160, 0, 0, 8'h7F);
    av(0, 1, 8'h66, 13'd7160, 0, 0, 8'h7F);
    av(0, 0, 8'hE3, 13'd8176, 0, 0, 8'h7F);
    // Vertical mode over a 2x2 window
    av(1, 0, 8'h20, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h01, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h21, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h00, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h01, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h22, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h00, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'h01, 13'd0,    0, 0, 8'h7F);
    av(0, 1, 8'h11, 13'd0,    0, 0, 8'h7F);
    av(0, 1, 8'h22, 13'd1024, 0, 0, 8'h7F);
    av(0, 1, 8'h33, 13'd8,    0, 0, 8'h7F);
    av(0, 1, 8'h44, 13'd1032, 0, 0, 8'h7F);
    av(0, 1, 8'h55, 13'd0,    0, 0, 8'h7F);
    av(0, 0, 8'hE3, 13'd1024, 0, 0, 8'h7F);
`else
    // Addressing-mode opcodes consume their arguments with no effect
    av(1, 0, 8'h20, 13'd0,  0, 0, 8'h7F);
    av(0, 0, 8'h00, 13'd0,  0, 0, 8'h7F);
    av(0, 0, 8'h21, 13'd0,  0, 0, 8'h7F);
    av(0, 0, 8'h7E, 13'd0,  0, 0, 8'h7F);
    av(0, 0, 8'h7F, 13'd0,  0, 0, 8'h7F);
    av(0, 0, 8'h22, 13'd0,  0, 0, 8'h7F);
    av(0, 0, 8'hB3, 13'd0,  0, 0, 8'h7F);
    av(0, 0, 8'hB5, 13'd0,  0, 0, 8'h7F);
    av(0, 1, 8'h11, 13'd0,  0, 0, 8'h7F);
    av(0, 1, 8'h22, 13'd8,  0, 0, 8'h7F);
    av(0, 0, 8'h20, 13'd16, 0, 0, 8'h7F);
    av(0, 0, 8'h01, 13'd16, 0, 0, 8'h7F);
    av(0, 1, 8'h33, 13'd16, 0, 0, 8'h7F);
    av(0, 0, 8'hE3, 13'd24, 0, 0, 8'h7F);
`endif

    repeat (2) @(posedge wclk);

    foreach (vecs[n]) begin
      string tag;
      tag = $sformatf("vec%0d", n);
      if (vecs[n].rst) do_reset(tag);
      send_byte(vecs[n].dc ? 8'hFF : 8'h00, vecs[n].b, vecs[n].addr, tag);
      chk_flags(tag, vecs[n].inv, vecs[n].on, vecs[n].con);
    end

    // Deselect mid-byte realigns the bit counter, nothing else changes
    do_reset("csn");
    send_bit(1'b0, 1'b1, 13'd0, "csn.p0");
    send_bit(1'b0, 1'b0, 13'd1, "csn.p1");
    send_bit(1'b0, 1'b1, 13'd2, "csn.p2");
    @(negedge wclk);
    cs_n = 1'b1; dc = 1'b1;
    #1;
    chk("csn.desel_fb_we", {31'd0, fb_we}, 32'd0);
    send_byte(8'h00, 8'hAF, 13'd0, "csn.af");
    chk_flags("csn.af", 1'b0, 1'b1, 8'h7F);
    send_byte(8'hFF, 8'h11, 13'd0, "csn.data");
    send_byte(8'h00, 8'hE3, 13'd8, "csn.after");

    // Reset in the middle of a two-argument command
    do_reset("rstcmd");
    send_byte(8'h00, 8'h21, 13'd0, "rstcmd.op");
    send_byte(8'h00, 8'h10, 13'd0, "rstcmd.a1");
    do_reset("rstcmd.mid");
    send_byte(8'h00, 8'hA7, 13'd0, "rstcmd.a7");
    chk_flags("rstcmd.a7", 1'b1, 1'b0, 8'h7F);
    send_byte(8'hFF, 8'h5A, 13'd0, "rstcmd.data");
    send_byte(8'h00, 8'hE3, 13'd8, "rstcmd.after");

    // Reset in the middle of a byte
    do_reset("rstbit");
    send_byte(8'h00, 8'hA7, 13'd0, "rstbit.a7");
    chk_flags("rstbit.a7", 1'b1, 1'b0, 8'h7F);
    for (int k = 0; k < 4; k++)
      send_bit(1'b1, 1'b1, 13'(k), "rstbit.part");
    do_reset("rstbit.mid");
    send_byte(8'hFF, 8'hC3, 13'd0, "rstbit.data");
    send_byte(8'h00, 8'hE3, 13'd8, "rstbit.after");

    // dc may change mid-byte; classification follows dc on the 8th bit
    do_reset("dcmix");
    send_byte(8'hFE, 8'hA7, 13'd0, "dcmix.cmd");
    chk_flags("dcmix.cmd", 1'b1, 1'b0, 8'h7F);
    send_byte(8'h01, 8'hA6, 13'd0, "dcmix.data");
    chk_flags("dcmix.data", 1'b1, 1'b0, 8'h7F);
    send_byte(8'h00, 8'hE3, 13'd8, "dcmix.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
